// File: rtl/iram_pi_reader.sv
// Pi readback port for IRAM: synchronised Pi strobes, 16-bit word fetch,
// returned as low byte then high byte over a four-phase ack handshake.
module iram_pi_reader #(
   parameter int ADDR_W      = 8,
   parameter int RAM_LAT     = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              gclk,
   input  logic              rst_n,
   input  logic              ComFlag,
   input  logic              PiStrobe,
   input  logic              PiAI,
   input  logic [7:0]        pi_din,
   output logic [7:0]        pi_dout,
   output logic              pi_dout_oe,
   output logic              PiAck,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd_en,
   input  logic [15:0]       ram_rdata,
   output logic              proto_err
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      PRESENT
   } state_t;

   localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

   state_t            state, state_n;
   logic [SYNC_STAGES-1:0] strobe_sync, ai_sync;
   logic              strobe_s, strobe_d;
   logic              rise_q, ai_q;
   logic [ADDR_W-1:0] addr_cnt, addr_n;
   logic              byte_sel, sel_n;
   logic [15:0]       word_q, word_n;
   logic [7:0]        dout_n;
   logic              oe_n, ack_n, err_n;
   logic [1:0]        lat_cnt, lat_n;

   assign strobe_s  = strobe_sync[SYNC_STAGES-1];
   assign ram_addr  = addr_cnt;
   assign ram_rd_en = ComFlag && (state == FETCH);

   // rise and the matching PiAI sample are registered together
   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_sync <= '0;
         ai_sync     <= '0;
         strobe_d    <= 1'b0;
         rise_q      <= 1'b0;
         ai_q        <= 1'b0;
      end else begin
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], PiStrobe};
         ai_sync     <= {ai_sync[SYNC_STAGES-2:0], PiAI};
         strobe_d    <= strobe_s;
         rise_q      <= strobe_s & ~strobe_d;
         ai_q        <= ai_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_cnt   <= '0;
         byte_sel   <= 1'b0;
         word_q     <= '0;
         pi_dout    <= '0;
         pi_dout_oe <= 1'b0;
         PiAck      <= 1'b0;
         proto_err  <= 1'b0;
         lat_cnt    <= '0;
      end else begin
         state      <= state_n;
         addr_cnt   <= addr_n;
         byte_sel   <= sel_n;
         word_q     <= word_n;
         pi_dout    <= dout_n;
         pi_dout_oe <= oe_n;
         PiAck      <= ack_n;
         proto_err  <= err_n;
         lat_cnt    <= lat_n;
      end
   end

   always_comb begin
      state_n = state;
      addr_n  = addr_cnt;
      sel_n   = byte_sel;
      word_n  = word_q;
      dout_n  = pi_dout;
      oe_n    = pi_dout_oe;
      ack_n   = PiAck;
      err_n   = proto_err;
      lat_n   = lat_cnt;
      if (!ComFlag) begin
         // pointer and word survive so a read pair can resume
         state_n = IDLE;
         oe_n    = 1'b0;
         ack_n   = 1'b0;
      end else begin
         if (rise_q && state != IDLE)
            err_n = 1'b1;
         unique case (state)
            IDLE: begin
               if (rise_q) begin
                  if (ai_q) begin
                     addr_n  = pi_din[ADDR_W-1:0];
                     sel_n   = 1'b0;
                     err_n   = 1'b0;
                     ack_n   = 1'b1;
                     state_n = PRESENT;
                  end else if (!byte_sel) begin
                     state_n = FETCH;
                  end else begin
                     dout_n  = word_q[15:8];
                     oe_n    = 1'b1;
                     ack_n   = 1'b1;
                     sel_n   = 1'b0;
                     addr_n  = addr_cnt + 1'b1;
                     state_n = PRESENT;
                  end
               end
            end
            FETCH: begin
               lat_n   = '0;
               state_n = WAIT;
            end
            WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  word_n  = ram_rdata;
                  dout_n  = ram_rdata[7:0];
                  oe_n    = 1'b1;
                  ack_n   = 1'b1;
                  sel_n   = 1'b1;
                  state_n = PRESENT;
               end else begin
                  lat_n = lat_cnt + 1'b1;
               end
            end
            PRESENT: begin
               if (!strobe_s) begin
                  ack_n   = 1'b0;
                  oe_n    = 1'b0;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule
